// File: rtl/io_button_conditioner.sv
// Button input conditioner: 2-flop synchronizer, per-bit debounce, registered press/release
// pulses and auto-repeat pulses while a button is held. Every bit is an independent channel.
module io_button_conditioner #(
  parameter int unsigned WIDTH           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_state,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release,
  output logic [WIDTH-1:0] btn_repeat
);

  localparam int unsigned DbW     = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HoldMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned HoldW   = (HoldMax > 1) ? $clog2(HoldMax) : 1;

  localparam logic [DbW-1:0]   DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] DelayLast = HoldW'(REPEAT_DELAY - 1);
  localparam logic [HoldW-1:0] RateLast  = HoldW'(REPEAT_RATE - 1);

  typedef enum logic {
    StInitial,
    StRepeat
  } phase_e;

  logic [WIDTH-1:0] sync_meta_q, sync_q;

  logic [DbW-1:0]   db_cnt_q [WIDTH];
  logic [DbW-1:0]   db_cnt_d [WIDTH];
  logic [WIDTH-1:0] flip;

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] rel_q, rel_d;
  logic [WIDTH-1:0] rpt_q, rpt_d;

  logic [HoldW-1:0] hold_cnt_q [WIDTH];
  logic [HoldW-1:0] hold_cnt_d [WIDTH];
  phase_e           phase_q    [WIDTH];
  phase_e           phase_d    [WIDTH];

  // btn_raw is asynchronous to clk; only sync_q is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
    end else begin
      sync_meta_q <= btn_raw;
      sync_q      <= sync_meta_q;
    end
  end

  // Any agreeing cycle restarts the count, so only a sustained disagreement flips the state.
  always_comb begin
    flip = '0;
    for (int i = 0; i < WIDTH; i++) begin
      db_cnt_d[i] = '0;
      if (sync_q[i] != state_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          flip[i] = 1'b1;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q ^ flip;
    press_d = flip & ~state_q;
    rel_d   = flip & state_q;
  end

  // Hold counting only runs in cycles where the button is down and not being released;
  // the release edge clears the count and suppresses any repeat due on that edge.
  always_comb begin
    rpt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hold_cnt_d[i] = '0;
      phase_d[i]    = StInitial;
      if (state_q[i] && !flip[i]) begin
        unique case (phase_q[i])
          StInitial: begin
            if (hold_cnt_q[i] == DelayLast) begin
              rpt_d[i]   = 1'b1;
              phase_d[i] = StRepeat;
            end else begin
              hold_cnt_d[i] = hold_cnt_q[i] + HoldW'(1);
            end
          end
          StRepeat: begin
            phase_d[i] = StRepeat;
            if (hold_cnt_q[i] == RateLast) begin
              rpt_d[i] = 1'b1;
            end else begin
              hold_cnt_d[i] = hold_cnt_q[i] + HoldW'(1);
            end
          end
          default: begin
            phase_d[i] = StInitial;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      rpt_q   <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        db_cnt_q[i]   <= '0;
        hold_cnt_q[i] <= '0;
        phase_q[i]    <= StInitial;
      end
    end else begin
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rpt_q   <= rpt_d;
      for (int i = 0; i < WIDTH; i++) begin
        db_cnt_q[i]   <= db_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
        phase_q[i]    <= phase_d[i];
      end
    end
  end

  assign btn_state   = state_q;
  assign btn_press   = press_q;
  assign btn_release = rel_q;
  assign btn_repeat  = rpt_q;

endmodule

// File: tb/tb_io_button_conditioner.sv
// Bench for io_button_conditioner: expected events are queued with their due cycle when the
// stimulus is applied, and a negedge monitor compares every output cycle against the queue.
module tb_io_button_conditioner;

  localparam int unsigned W  = 5;
  localparam int unsigned DC = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RR = 8;
  localparam int          LAT = 2 + DC;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] btn_raw;
  logic [W-1:0] btn_state;
  logic [W-1:0] btn_press;
  logic [W-1:0] btn_release;
  logic [W-1:0] btn_repeat;

  typedef struct {
    int           cyc;
    logic [W-1:0] press;
    logic [W-1:0] rel;
    logic [W-1:0] rpt;
  } ev_t;

  ev_t          sb_q[$];
  logic [W-1:0] exp_state;
  int           cyc;
  int           checks;
  int           failures;

  io_button_conditioner #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_state  (btn_state),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_ev(input int c, input logic [W-1:0] p, input logic [W-1:0] r,
                         input logic [W-1:0] t);
    ev_t e;
    e.cyc   = c;
    e.press = p;
    e.rel   = r;
    e.rpt   = t;
    sb_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: anything not queued for this cycle must be zero on the event outputs.
  initial begin
    ev_t          e;
    logic [W-1:0] e_press, e_rel, e_rpt;
    forever begin
      @(negedge clk);
      e_press = '0;
      e_rel   = '0;
      e_rpt   = '0;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        if (e.cyc < cyc) begin
          checks++;
          failures++;
          $display("FAIL sb_stale cyc=%0d entry_cyc=%0d", cyc, e.cyc);
        end else begin
          e_press |= e.press;
          e_rel   |= e.rel;
          e_rpt   |= e.rpt;
        end
      end
      exp_state = (exp_state | e_press) & ~e_rel;
      checks += 4;
      if (btn_state !== exp_state) begin
        failures++;
        $display("FAIL mon_state cyc=%0d got=%h exp=%h", cyc, btn_state, exp_state);
      end
      if (btn_press !== e_press) begin
        failures++;
        $display("FAIL mon_press cyc=%0d got=%h exp=%h", cyc, btn_press, e_press);
      end
      if (btn_release !== e_rel) begin
        failures++;
        $display("FAIL mon_release cyc=%0d got=%h exp=%h", cyc, btn_release, e_rel);
      end
      if (btn_repeat !== e_rpt) begin
        failures++;
        $display("FAIL mon_repeat cyc=%0d got=%h exp=%h", cyc, btn_repeat, e_rpt);
      end
    end
  end

  task automatic test_reset();
    int r;
    wait_cycles(3);
    checks++;
    if ({btn_state, btn_press, btn_release, btn_repeat} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {btn_state, btn_press, btn_release, btn_repeat});
    end
    r = cyc;
    rst_n = 1'b1;
    push_ev(r + LAT, 5'h1F, '0, '0);
    wait_cycles(LAT);
    checks++;
    if (btn_press !== 5'h1F || btn_state !== 5'h1F) begin
      failures++;
      $display("FAIL reset_fresh_press press=%h state=%h exp=1f", btn_press, btn_state);
    end
    wait_cycles(2);
    btn_raw = '0;
    push_ev(r + 8 + LAT, '0, 5'h1F, '0);
    wait_cycles(LAT + 2);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL reset_drain pending=%0d exp=0", sb_q.size());
    end
  endtask

  task automatic test_clean_press();
    int t;
    t = cyc;
    btn_raw[0] = 1'b1;
    push_ev(t + LAT, 5'h01, '0, '0);
    wait_cycles(10);
    btn_raw[0] = 1'b0;
    push_ev(t + 10 + LAT, '0, 5'h01, '0);
    wait_cycles(LAT);
    checks++;
    if (btn_release[0] !== 1'b1 || btn_state[0] !== 1'b0) begin
      failures++;
      $display("FAIL clean_release rel=%b state=%b exp rel=1 state=0",
               btn_release[0], btn_state[0]);
    end
    wait_cycles(4);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL clean_drain pending=%0d exp=0", sb_q.size());
    end
  endtask

  task automatic test_bounce();
    int t;
    t = cyc;
    for (int k = 0; k < 4; k++) begin
      btn_raw[2] = (k % 2 == 0);
      wait_cycles(2);
    end
    btn_raw[2] = 1'b1;
    push_ev(t + 8 + LAT, 5'h04, '0, '0);
    wait_cycles(10);
    btn_raw[2] = 1'b0;
    push_ev(t + 18 + LAT, '0, 5'h04, '0);
    wait_cycles(LAT + 2);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL bounce_drain pending=%0d exp=0", sb_q.size());
    end
  endtask

  task automatic test_glitch();
    btn_raw[3] = 1'b1;
    wait_cycles(DC - 1);
    btn_raw[3] = 1'b0;
    wait_cycles(12);
    checks++;
    if (btn_state[3] !== 1'b0) begin
      failures++;
      $display("FAIL glitch_state got=%b exp=0", btn_state[3]);
    end
  endtask

  task automatic test_auto_repeat();
    int p;
    p = cyc + LAT;
    btn_raw[1] = 1'b1;
    push_ev(p, 5'h02, '0, '0);
    push_ev(p + RD, '0, '0, 5'h02);
    push_ev(p + RD + RR, '0, '0, 5'h02);
    push_ev(p + RD + 2 * RR, '0, '0, 5'h02);
    // Release lands exactly where the next repeat would have fired.
    wait_cycles(RD + 2 * RR + 2 + LAT);
    btn_raw[1] = 1'b0;
    push_ev(p + RD + 3 * RR, '0, 5'h02, '0);
    wait_cycles(LAT);
    checks++;
    if (btn_release[1] !== 1'b1 || btn_repeat[1] !== 1'b0) begin
      failures++;
      $display("FAIL repeat_release rel=%b rpt=%b exp rel=1 rpt=0",
               btn_release[1], btn_repeat[1]);
    end
    wait_cycles(RD);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL repeat_drain pending=%0d exp=0", sb_q.size());
    end
  endtask

  task automatic test_independence_async_reset();
    int t;
    int r;
    t = cyc;
    btn_raw = 5'h11;
    push_ev(t + LAT, 5'h11, '0, '0);
    wait_cycles(10);
    checks++;
    if (btn_state !== 5'h11) begin
      failures++;
      $display("FAIL indep_state got=%h exp=11", btn_state);
    end
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    exp_state = '0;
    #1;
    checks++;
    if ({btn_state, btn_press, btn_release, btn_repeat} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0",
               {btn_state, btn_press, btn_release, btn_repeat});
    end
    wait_cycles(3);
    r = cyc;
    rst_n = 1'b1;
    push_ev(r + LAT, 5'h11, '0, '0);
    wait_cycles(8);
    btn_raw = '0;
    push_ev(r + 8 + LAT, '0, 5'h11, '0);
    wait_cycles(LAT + 2);
    checks++;
    if (sb_q.size() != 0 || btn_state !== '0) begin
      failures++;
      $display("FAIL reassert_drain pending=%0d state=%h exp 0/0", sb_q.size(), btn_state);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_state = '0;
    rst_n     = 1'b0;
    btn_raw   = 5'h1F;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_auto_repeat();
    test_independence_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
